// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, bus bit meanings and
// small elaboration-time helpers used by the responder and the controller.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_REG_ADDR = 4'd3,
        ST_REG_ACK  = 4'd4,
        ST_WR_DATA  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_DATA  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and reports SCL edges plus START/STOP
// conditions as registered single-cycle pulses aligned with the sampled SDA.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;
    logic       sda_r;
    logic       scl_rise_r;
    logic       scl_fall_r;
    logic       start_r;
    logic       stop_r;

    // Two-stage synchronizers, one history stage, and registered event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
            sda_r      <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl};
            sda_sync_r <= {sda_sync_r[0], sda};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
            sda_r      <= sda_sync_r[1];
            scl_rise_r <= scl_sync_r[1] & ~scl_prev_r;
            scl_fall_r <= ~scl_sync_r[1] & scl_prev_r;
            // SDA moving while SCL is held high in both samples
            start_r    <= scl_sync_r[1] & scl_prev_r & sda_prev_r & ~sda_sync_r[1];
            stop_r     <= scl_sync_r[1] & scl_prev_r & ~sda_prev_r & sda_sync_r[1];
        end
    end

    assign sda_s     = sda_r;
    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;

endmodule

// File: rtl/basic_i2c_slave.sv
// I2C register-access responder: device address match, register pointer
// write, byte writes with auto-increment, and sequential reads.
module basic_i2c_slave #(
    parameter int                        SYS_CLOCK_FREQ     = 100_000_000,
    parameter int                        SCL_FREQ           = 10_000_000,
    parameter int                        DEV_ADDR_WIDTH     = 7,
    parameter logic [DEV_ADDR_WIDTH-1:0] DEV_ADDR           = 7'h55,
    parameter int                        DEV_REG_ADDR_WIDTH = 8,
    parameter int                        DATA_WIDTH         = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic [DEV_REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0]         reg_wr_data_o,
    output logic                          reg_wr_en_o,
    output logic                          reg_rd_en_o,
    input  logic [DATA_WIDTH-1:0]         reg_rd_data_i,
    output logic                          busy_o,
    inout  wire                           i2c_serial_data,
    input  logic                          i2c_serial_clk
);
    import i2c_pkg::*;

    localparam int SH_W = max3(DEV_ADDR_WIDTH + 1, DEV_REG_ADDR_WIDTH, DATA_WIDTH);
    localparam logic [7:0] DEV_BITS  = 8'(DEV_ADDR_WIDTH + 1);
    localparam logic [7:0] REG_BITS  = 8'(DEV_REG_ADDR_WIDTH);
    localparam logic [7:0] DATA_BITS = 8'(DATA_WIDTH);
    localparam logic [DEV_REG_ADDR_WIDTH-1:0] ADDR_ONE = DEV_REG_ADDR_WIDTH'(1);

    if (SYS_CLOCK_FREQ < 8 * SCL_FREQ) begin : g_freq_check
        $error("basic_i2c_slave: SYS_CLOCK_FREQ must be at least 8 * SCL_FREQ");
    end

    logic sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

    i2c_line_sync u_line_sync (
        .clk       (clk_i),
        .rst       (rst_i),
        .scl       (i2c_serial_clk),
        .sda       (i2c_serial_data),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_s),
        .stop_det  (stop_s)
    );

    i2c_state_t                    state_r;
    logic [7:0]                    bit_cnt_r;
    logic [SH_W-1:0]               shift_r;
    logic [DEV_REG_ADDR_WIDTH-1:0] reg_addr_r;
    logic [DATA_WIDTH-1:0]         wr_data_r;
    logic                          wr_en_r, rd_en_r, rd_latch_r;
    logic                          sda_oe_r, busy_r, rw_r;
    logic                          ack_phase_r, rd_ack_r, rd_done_r;
    logic [SH_W-1:0]               shift_nx_s;
    logic [7:0]                    cnt_nx_s;

    assign shift_nx_s = {shift_r[SH_W-2:0], sda_s};
    assign cnt_nx_s   = bit_cnt_r + 8'd1;

    // Protocol FSM: STOP/START take priority, then read-data load, then SCL edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 8'd0;
            shift_r     <= '0;
            reg_addr_r  <= '0;
            wr_data_r   <= '0;
            wr_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_latch_r  <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            rw_r        <= I2C_WRITE;
            ack_phase_r <= 1'b0;
            rd_ack_r    <= I2C_NACK;
            rd_done_r   <= 1'b0;
        end else begin
            wr_en_r    <= 1'b0;
            rd_en_r    <= 1'b0;
            rd_latch_r <= rd_en_r;
            if (stop_s) begin
                state_r     <= ST_IDLE;
                sda_oe_r    <= 1'b0;
                busy_r      <= 1'b0;
                bit_cnt_r   <= 8'd0;
                ack_phase_r <= 1'b0;
                rd_done_r   <= 1'b0;
                rd_latch_r  <= 1'b0;
            end else if (start_s) begin
                state_r     <= ST_DEV_ADDR;
                sda_oe_r    <= 1'b0;
                bit_cnt_r   <= 8'd0;
                ack_phase_r <= 1'b0;
                rd_done_r   <= 1'b0;
                rd_latch_r  <= 1'b0;
            end else if (rd_latch_r && (state_r == ST_RD_DATA)) begin
                // Read byte arrives now; MSB goes straight to the line, rest kept pre-shifted
                shift_r  <= {reg_rd_data_i[DATA_WIDTH-2:0], {(SH_W-DATA_WIDTH+1){1'b0}}};
                sda_oe_r <= ~reg_rd_data_i[DATA_WIDTH-1];
            end else if (scl_rise_s) begin
                case (state_r)
                    ST_DEV_ADDR: begin
                        shift_r   <= shift_nx_s;
                        bit_cnt_r <= cnt_nx_s;
                        if (cnt_nx_s == DEV_BITS) begin
                            if (shift_nx_s[DEV_ADDR_WIDTH:1] == DEV_ADDR) begin
                                state_r <= ST_DEV_ACK;
                                busy_r  <= 1'b1;
                                rw_r    <= shift_nx_s[0];
                            end else begin
                                state_r <= ST_IGNORE;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                    ST_REG_ADDR: begin
                        shift_r   <= shift_nx_s;
                        bit_cnt_r <= cnt_nx_s;
                        if (cnt_nx_s == REG_BITS) begin
                            reg_addr_r <= shift_nx_s[DEV_REG_ADDR_WIDTH-1:0];
                            state_r    <= ST_REG_ACK;
                        end
                    end
                    ST_WR_DATA: begin
                        shift_r   <= shift_nx_s;
                        bit_cnt_r <= cnt_nx_s;
                        if (cnt_nx_s == DATA_BITS) begin
                            wr_data_r <= shift_nx_s[DATA_WIDTH-1:0];
                            wr_en_r   <= 1'b1;
                            state_r   <= ST_WR_ACK;
                        end
                    end
                    ST_RD_DATA: bit_cnt_r <= cnt_nx_s;
                    ST_RD_ACK: begin
                        if (!rd_done_r) begin
                            rd_ack_r <= sda_s;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                        // First fall drives the ACK, second fall ends the ACK clock
                        if (!ack_phase_r) begin
                            sda_oe_r    <= 1'b1;
                            ack_phase_r <= 1'b1;
                            if (state_r == ST_WR_ACK) begin
                                reg_addr_r <= reg_addr_r + ADDR_ONE;
                            end
                        end else begin
                            sda_oe_r    <= 1'b0;
                            ack_phase_r <= 1'b0;
                            bit_cnt_r   <= 8'd0;
                            if (state_r != ST_DEV_ACK) begin
                                state_r <= ST_WR_DATA;
                            end else if (rw_r == I2C_READ) begin
                                state_r <= ST_RD_DATA;
                                rd_en_r <= 1'b1;
                            end else begin
                                state_r <= ST_REG_ADDR;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (bit_cnt_r == DATA_BITS) begin
                            sda_oe_r  <= 1'b0;
                            bit_cnt_r <= 8'd0;
                            state_r   <= ST_RD_ACK;
                        end else begin
                            sda_oe_r <= ~shift_r[SH_W-1];
                            shift_r  <= {shift_r[SH_W-2:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: begin
                        if (!rd_done_r) begin
                            if (rd_ack_r == I2C_ACK) begin
                                reg_addr_r <= reg_addr_r + ADDR_ONE;
                                rd_en_r    <= 1'b1;
                                state_r    <= ST_RD_DATA;
                            end else begin
                                rd_done_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign i2c_serial_data = sda_oe_r ? 1'b0 : 1'bz;
    assign reg_addr_o      = reg_addr_r;
    assign reg_wr_data_o   = wr_data_r;
    assign reg_wr_en_o     = wr_en_r;
    assign reg_rd_en_o     = rd_en_r;
    assign busy_o          = busy_r;

endmodule

// File: tb/tb_basic_i2c_slave.sv
// Bench for basic_i2c_slave: a task-level bus controller issues directed
// transactions while a monitor scores strobes and observed bus responses.
module tb_basic_i2c_slave;

    localparam int Q = 10;

    typedef struct { string name; int val; } item_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda_low;
    wire        i2c_sda;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    logic       reg_wr_en, reg_rd_en, busy;
    logic [7:0] mem [256];

    item_t      exp_q[$];
    item_t      obs_q[$];
    wr_t        wr_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic       watch_sda = 1'b0;
    logic       stim_done = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 tb_clk = ~tb_clk;

    pullup (i2c_sda);
    assign i2c_sda = m_sda_low ? 1'b0 : 1'bz;

    basic_i2c_slave dut (
        .clk_i           (tb_clk),
        .rst_i           (rst),
        .reg_addr_o      (reg_addr),
        .reg_wr_data_o   (reg_wr_data),
        .reg_wr_en_o     (reg_wr_en),
        .reg_rd_en_o     (reg_rd_en),
        .reg_rd_data_i   (reg_rd_data),
        .busy_o          (busy),
        .i2c_serial_data (i2c_sda),
        .i2c_serial_clk  (scl)
    );

    // Register file model: read data valid the cycle after the strobe
    always @(posedge tb_clk) begin
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];
    end

    task automatic half();
        repeat (Q) @(negedge tb_clk);
    endtask

    task automatic expect_val(input string n, input int v);
        exp_q.push_back('{n, v});
    endtask

    task automatic observe(input string n, input int v);
        obs_q.push_back('{n, v});
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; half();
        scl = 1'b1;       half();
        m_sda_low = 1'b1; half();
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        half(); m_sda_low = 1'b1;
        half(); scl = 1'b1;
        half(); m_sda_low = 1'b0;
        half();
    endtask

    task automatic send_bit(input logic b);
        half(); m_sda_low = ~b;
        half(); scl = 1'b1;
        half(); half(); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        half(); m_sda_low = 1'b0;
        half(); scl = 1'b1;
        half(); b = i2c_sda;
        half(); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string n);
        logic a;
        expect_val(n, int'(exp_ack));
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        observe(n, int'(a));
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic ack, input string n);
        logic [7:0] d;
        logic       b;
        expect_val(n, int'(exp_d));
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
        observe(n, int'(d));
    endtask

    initial begin : stimulus
        logic [7:0] dv;
        rst = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'hC3;
        repeat (5) @(negedge tb_clk);
        expect_val("rst_busy", 0);     observe("rst_busy", int'(busy));
        expect_val("rst_addr", 0);     observe("rst_addr", int'(reg_addr));
        expect_val("rst_wdata", 0);    observe("rst_wdata", int'(reg_wr_data));
        expect_val("rst_wr_en", 0);    observe("rst_wr_en", int'(reg_wr_en));
        expect_val("rst_rd_en", 0);    observe("rst_rd_en", int'(reg_rd_en));
        expect_val("rst_sda", 1);      observe("rst_sda", int'(i2c_sda));
        rst = 1'b0; half();

        // single write 0xFF to 0xAA
        i2c_start();
        write_byte(8'hAA, 1'b0, "wr_dev_ack");
        write_byte(8'hAA, 1'b0, "wr_reg_ack");
        wr_exp_q.push_back('{8'hAA, 8'hFF});
        write_byte(8'hFF, 1'b0, "wr_data_ack");
        expect_val("busy_before_stop", 1); observe("busy_before_stop", int'(busy));
        i2c_stop();
        expect_val("busy_after_stop", 0);  observe("busy_after_stop", int'(busy));
        expect_val("addr_after_write", 8'hAB); observe("addr_after_write", int'(reg_addr));

        // pointer write, repeated START, two-byte read
        i2c_start();
        write_byte(8'hAA, 1'b0, "rd_dev_w_ack");
        write_byte(8'h10, 1'b0, "rd_reg_ack");
        i2c_start();
        rd_exp_q.push_back(8'h10);
        write_byte(8'hAB, 1'b0, "rd_dev_r_ack");
        rd_exp_q.push_back(8'h11);
        read_byte(8'h5A, 1'b0, "rd_byte0");
        read_byte(8'hC3, 1'b1, "rd_byte1");
        i2c_stop();
        expect_val("addr_after_read", 8'h11); observe("addr_after_read", int'(reg_addr));

        // foreign device address 0x22
        watch_sda = 1'b1;
        i2c_start();
        write_byte(8'h44, 1'b1, "mm_dev_nack");
        expect_val("mm_busy", 0); observe("mm_busy", int'(busy));
        write_byte(8'h00, 1'b1, "mm_data_nack");
        i2c_stop();
        watch_sda = 1'b0;

        // burst across the address wrap
        i2c_start();
        write_byte(8'hAA, 1'b0, "bu_dev_ack");
        write_byte(8'hFE, 1'b0, "bu_reg_ack");
        wr_exp_q.push_back('{8'hFE, 8'h01});
        wr_exp_q.push_back('{8'hFF, 8'h02});
        wr_exp_q.push_back('{8'h00, 8'h03});
        write_byte(8'h01, 1'b0, "bu_d0_ack");
        write_byte(8'h02, 1'b0, "bu_d1_ack");
        write_byte(8'h03, 1'b0, "bu_d2_ack");
        i2c_stop();
        expect_val("addr_after_burst", 8'h01); observe("addr_after_burst", int'(reg_addr));

        // STOP after four data bits: byte discarded
        i2c_start();
        write_byte(8'hAA, 1'b0, "ab_dev_ack");
        write_byte(8'h30, 1'b0, "ab_reg_ack");
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        expect_val("ab_busy", 0);    observe("ab_busy", int'(busy));
        expect_val("ab_addr", 8'h30); observe("ab_addr", int'(reg_addr));

        // reset while the responder is driving the address ACK
        dv = 8'hAA;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(dv[i]);
        m_sda_low = 1'b0;
        half();
        expect_val("ack_before_rst", 0); observe("ack_before_rst", int'(i2c_sda));
        rst = 1'b1;
        #1;
        expect_val("sda_in_rst", 1);  observe("sda_in_rst", int'(i2c_sda));
        expect_val("busy_in_rst", 0); observe("busy_in_rst", int'(busy));
        repeat (3) @(negedge tb_clk);
        rst = 1'b0;
        expect_val("addr_after_rst", 0); observe("addr_after_rst", int'(reg_addr));
        half(); scl = 1'b1; half();

        // recovery write after reset
        i2c_start();
        write_byte(8'hAA, 1'b0, "rc_dev_ack");
        write_byte(8'h07, 1'b0, "rc_reg_ack");
        wr_exp_q.push_back('{8'h07, 8'h9C});
        write_byte(8'h9C, 1'b0, "rc_data_ack");
        i2c_stop();

        repeat (5) @(negedge tb_clk);
        stim_done = 1'b1;
    end

    initial begin : monitor
        int    cycles;
        int    sda_low_cnt;
        logic  watch_prev;
        item_t e, o;
        wr_t   w;
        logic [7:0] ra;
        cycles = 0; sda_low_cnt = 0; watch_prev = 1'b0;
        while (!stim_done && cycles < 60000) begin
            @(negedge tb_clk);
            cycles++;
            if (reg_wr_en) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_strobe: got addr=%02h data=%02h, expected no write", reg_addr, reg_wr_data);
                end else begin
                    w = wr_exp_q.pop_front();
                    if (reg_addr !== w.addr || reg_wr_data !== w.data) begin
                        failures++;
                        $display("FAIL wr_strobe: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                                 reg_addr, reg_wr_data, w.addr, w.data);
                    end
                end
            end
            if (reg_rd_en) begin
                checks++;
                if (rd_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_strobe: got addr=%02h, expected no read", reg_addr);
                end else begin
                    ra = rd_exp_q.pop_front();
                    if (reg_addr !== ra) begin
                        failures++;
                        $display("FAIL rd_strobe: got addr=%02h, expected addr=%02h", reg_addr, ra);
                    end
                end
            end
            if (watch_sda && i2c_sda === 1'b0 && !m_sda_low) sda_low_cnt++;
            if (watch_prev && !watch_sda) begin
                checks++;
                if (sda_low_cnt != 0) begin
                    failures++;
                    $display("FAIL mm_sda_low: got %0d cycles of SDA driven low, expected 0", sda_low_cnt);
                end
            end
            watch_prev = watch_sda;
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s: got %0h, expected nothing queued", o.name, o.val);
                end else begin
                    e = exp_q.pop_front();
                    if (e.name != o.name || e.val != o.val) begin
                        failures++;
                        $display("FAIL %s: got %0h, expected %0h (%s)", o.name, o.val, e.val, e.name);
                    end
                end
            end
        end
        checks++;
        if (!stim_done) begin
            failures++;
            $display("FAIL timeout: got %0d cycles without completion, expected fewer than 60000", cycles);
        end
        checks++;
        if (wr_exp_q.size() != 0) begin
            failures++;
            $display("FAIL wr_pending: got %0d missing write strobes, expected 0", wr_exp_q.size());
        end
        checks++;
        if (rd_exp_q.size() != 0) begin
            failures++;
            $display("FAIL rd_pending: got %0d missing read strobes, expected 0", rd_exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/basic_i2c_slave.md
BASIC_I2C_SLAVE -- requirements
Module: basic_i2c_slave

Interface
REQ-001 Parameter SYS_CLOCK_FREQ, default 100_000_000, SHALL set the system clock frequency in Hz.
REQ-002 Parameter SCL_FREQ, default 10_000_000, SHALL set the maximum supported SCL rate in Hz; SYS_CLOCK_FREQ >= 8*SCL_FREQ (elaboration assertion).
REQ-003 Parameter DEV_ADDR_WIDTH, default 7, SHALL set the device address width.
REQ-004 Parameter DEV_ADDR, default 7'h55, SHALL set the responder's own address.
REQ-005 Parameter DEV_REG_ADDR_WIDTH, default 8, SHALL set the register address width.
REQ-006 Parameter DATA_WIDTH, default 8, SHALL set the data byte width.
REQ-007 clk_i  input  1  system clock; the only clock; all logic on its rising edge.
REQ-008 rst_i  input  1  reset, asynchronous, active-high.
REQ-009 reg_addr_o  output  DEV_REG_ADDR_WIDTH  current register address.
REQ-010 reg_wr_data_o  output  DATA_WIDTH  received write byte.
REQ-011 reg_wr_en_o  output  1  one-cycle strobe qualifying reg_addr_o/reg_wr_data_o.
REQ-012 reg_rd_en_o  output  1  one-cycle strobe requesting the byte at reg_addr_o.
REQ-013 reg_rd_data_i  input  DATA_WIDTH  read byte, valid the cycle after reg_rd_en_o.
REQ-014 busy_o  output  1  high from addressed START to STOP.
REQ-015 i2c_serial_data  inout  1  SDA, open-drain: drives 0 or Z only.
REQ-016 i2c_serial_clk  input  1  SCL; never driven (no clock stretching).

Function
REQ-017 SDA and SCL SHALL pass through 2-FF synchronizers; edges/START/STOP are detected from the synchronized values.
REQ-018 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both detected in any state, and START (incl. repeated) SHALL force DEV_ADDR with bit counter cleared.
REQ-019 Bits SHALL be sampled on SCL rising edge, MSB first; SDA output changes only on the detected SCL falling edge.
REQ-020 States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-021 DEV_ADDR: after 8 bits, address == DEV_ADDR -> DEV_ACK (SDA low for the 9th clock); mismatch -> IGNORE (SDA Z until START/STOP).
REQ-022 R/W=0 -> REG_ADDR; R/W=1 -> RD_DATA using the stored reg_addr_o.
REQ-023 REG_ADDR: 8 bits loaded into reg_addr_o, ACKed, then WR_DATA.
REQ-024 WR_DATA: after 8 bits, reg_wr_en_o pulses one cycle with the byte, ACK driven, reg_addr_o increments (wraps 0xFF->0x00) on the following SCL falling edge.
REQ-025 RD_DATA: reg_rd_en_o pulses on the falling edge ending DEV_ACK/RD_ACK; byte latched next cycle and shifted out MSB first.
REQ-026 RD_ACK: master ACK (0) -> increment address, next RD_DATA; NACK (1) -> release SDA, wait STOP/START.
REQ-027 STOP in any state -> IDLE, SDA released; an unfinished WR_DATA byte is discarded (no reg_wr_en_o).
REQ-028 busy_o SHALL be 1 from the DEV_ACK entry to STOP; 0 in IDLE and IGNORE.
REQ-029 reg_addr_o SHALL persist across transactions until overwritten.

Reset
REQ-030 On rst_i: state IDLE, SDA Z, reg_addr_o 0, reg_wr_data_o 0, strobes 0, busy_o 0, synchronizers 1.
REQ-031 Reset asserted mid-transaction SHALL release SDA immediately; no strobe issues until next START.

Structure
REQ-032 Package i2c_pkg SHALL hold the state enum and ACK/NACK, READ/WRITE bit constants, shared with basic_i2c_master.
REQ-033 Sub-module i2c_line_sync SHALL implement synchronizers and rise/fall/START/STOP detection.

Verification
REQ-034 Write: basic_i2c_master dev 0x55, reg 0xAA, data 0xFF -> three ACKs, one reg_wr_en_o pulse with addr 0xAA / data 0xFF, busy_o drops after STOP.
REQ-035 Read: reg 0x10, reg_rd_data_i=0x5A -> SDA carries 0x5A, master read_data_o = 0x5A after NACK/STOP.
REQ-036 Mismatch: address 0x22 -> SDA never driven low, no strobes, busy_o stays 0.
REQ-037 Burst: write 0xFE then three bytes 0x01,0x02,0x03 -> wr strobes at 0xFE, 0xFF, 0x00.
REQ-038 Abort: STOP after 4 data bits -> IDLE, no reg_wr_en_o; rst_i pulse mid-DEV_ACK -> SDA Z within same cycle.
